// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and synchronizer depth.
// Optional build macro UART_RX_PARITY_EN adds the receiver PARITY state.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_SYNC_DEPTH = 2;
  localparam int unsigned UART_CNT_W      = 16;
  localparam int unsigned UART_BIT_CNT_W  = 3;

  // One-hot receiver states
  typedef enum logic [4:0] {
    RX_IDLE   = 5'b00001,
    RX_START  = 5'b00010,
    RX_DATA   = 5'b00100,
`ifdef UART_RX_PARITY_EN
    RX_PARITY = 5'b01000,
`endif
    RX_STOP   = 5'b10000
  } rx_state_e;

  // Effective clocks per bit: 0 selects the default, anything below 2 is raised to 2
  function automatic logic [UART_CNT_W-1:0] uart_eff_div(input logic [UART_CNT_W-1:0] div,
                                                         input logic [UART_CNT_W-1:0] dflt);
    logic [UART_CNT_W-1:0] n;
    n = (div == '0) ? dflt : div;
    if (n < UART_CNT_W'(2)) n = UART_CNT_W'(2);
    return n;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input, with selectable reset value.
module uart_sync
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH   = UART_SYNC_DEPTH,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  // Shift the raw input through the flop chain
  always_ff @(posedge clk) begin
    if (!rst) sync_q <= {DEPTH{RST_VAL}};
    else      sync_q <= {sync_q[DEPTH-2:0], d_i};
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, runtime divisor, ready/valid output with overrun flag.
// Optional build macro UART_RX_PARITY_EN adds a parity bit (parity_odd / parity_err ports).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ    = 100000000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned BAUD_CLOCK_NR = CLOCK_FREQ / BAUD_RATE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rxd,
  input  logic [UART_CNT_W-1:0]     baud_div,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      rx_busy,
  output logic                      frame_err,
  output logic                      overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                      parity_err,
  input  logic                      parity_odd
`endif
);

  localparam int unsigned DW      = UART_DATA_BITS;
  localparam int unsigned CW      = UART_CNT_W;
  localparam int unsigned BW      = UART_BIT_CNT_W;
  localparam int unsigned FLUSH_W = $clog2(UART_SYNC_DEPTH + 1);
  localparam logic [CW-1:0] DFLT_DIV = CW'(BAUD_CLOCK_NR);

  logic               rxd_s;
  rx_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [CW-1:0]      n_q, n_d;
  logic [DW-1:0]      shift_q, shift_d;
  logic [DW-1:0]      data_q, data_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;
  logic               busy_q, busy_d;
  logic               prev_q;
  logic               armed_q;
  logic [FLUSH_W-1:0] flush_q;
  logic [CW-1:0]      n_eff;
  logic               start_edge;
  logic               deliver;
  logic               hs;
`ifdef UART_RX_PARITY_EN
  logic               perr_q, perr_d;
  logic               pbad_q, pbad_d;
`endif

  uart_sync #(
    .DEPTH   (UART_SYNC_DEPTH),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rxd),
    .q_o (rxd_s)
  );

  // Start-edge qualifier: armed only once the synchronizer has flushed and shown an idle line
  always_ff @(posedge clk) begin
    if (!rst) begin
      flush_q <= '0;
      armed_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      if (flush_q != FLUSH_W'(UART_SYNC_DEPTH)) flush_q <= flush_q + FLUSH_W'(1);
      armed_q <= armed_q | ((flush_q == FLUSH_W'(UART_SYNC_DEPTH)) & rxd_s);
      prev_q  <= rxd_s;
    end
  end

  assign n_eff      = uart_eff_div(baud_div, DFLT_DIV);
  assign start_edge = armed_q & prev_q & ~rxd_s;
  assign hs         = valid_q & rx_ready;

  // Frame sequencing, bit sampling and output handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    n_d     = n_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = 1'b0;
    pbad_d  = pbad_q;
`endif

    unique case (state_q)
      RX_IDLE: begin
        if (start_edge) begin
          state_d = RX_START;
          n_d     = n_eff;
          cnt_d   = (n_eff >> 1) - CW'(1);
`ifdef UART_RX_PARITY_EN
          pbad_d  = 1'b0;
`endif
        end
      end
      RX_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rxd_s) begin
          state_d = RX_DATA;
          cnt_d   = n_q - CW'(1);
          bit_d   = '0;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d = {rxd_s, shift_q[DW-1:1]};
          cnt_d   = n_q - CW'(1);
          bit_d   = bit_q + BW'(1);
          if (bit_q == BW'(DW - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          if ((^shift_q ^ rxd_s) != parity_odd) begin
            perr_d = 1'b1;
            pbad_d = 1'b1;
          end
          cnt_d   = n_q - CW'(1);
          state_d = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = RX_IDLE;
          cnt_d   = '0;
          if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
            deliver = ~pbad_q;
`else
            deliver = 1'b1;
`endif
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = RX_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (deliver) begin
      if (!valid_q || hs) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (hs) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != RX_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      n_q     <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      pbad_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
      pbad_q  <= pbad_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = busy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: vector table of single frames plus hand-written corner sequences.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic [15:0] baud_div;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_busy;
  logic        frame_err;
  logic        overrun;
`ifdef UART_RX_PARITY_EN
  logic        parity_err;
  logic        parity_odd;
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  uart_rx #(
    .CLOCK_FREQ (100000000),
    .BAUD_RATE  (115200)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .baud_div  (baud_div),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err),
    .parity_odd(parity_odd)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor
  int         valid_cycles, acc_cnt, ferr_cnt, ovr_cnt, perr_cnt, first_valid, start_cyc;
  logic       busy_seen;
  logic [7:0] last_data;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cycles++;
      if (first_valid < 0) first_valid = cyc;
      if (rx_ready) begin
        acc_cnt++;
        last_data = rx_data;
      end
    end
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (rx_busy) busy_seen = 1'b1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_cnt++;
`endif
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    valid_cycles = 0; acc_cnt = 0; ferr_cnt = 0; ovr_cnt = 0; perr_cnt = 0;
    first_valid = -1; busy_seen = 1'b0; last_data = 8'h00;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    rxd = b;
    tick(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                            input int nb, input logic swap);
    logic [15:0] saved;
    saved     = baud_div;
    start_cyc = cyc;
    drive_bit(1'b0, nb);
    if (swap) baud_div = 16'd8;
    for (int i = 0; i < 8; i++) drive_bit(d[i], nb);
`ifdef UART_RX_PARITY_EN
    drive_bit(par, nb);
`else
    if (par) rxd = 1'b1;
`endif
    drive_bit(stop, nb);
    rxd      = 1'b1;
    baud_div = saved;
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic        par;
    logic [15:0] div;
    int          nb;
    logic        swap;
    int          exp_valid;
    logic [7:0]  exp_data;
    int          exp_ferr;
    int          exp_perr;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  initial begin
    rst = 1'b0; rxd = 1'b1; rx_ready = 1'b1; baud_div = 16'd16;
`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
`endif
    clear_mon();
    tick(4);
    check("reset_valid", int'(rx_valid), 0);
    check("reset_data", int'(rx_data), 0);
    check("reset_busy", int'(rx_busy), 0);
    check("reset_ferr", int'(frame_err), 0);
    check("reset_ovr", int'(overrun), 0);
    rst = 1'b1;
    tick(10);

    // data, stop, par, div, clocks/bit, swap divisor mid-frame, exp valid, exp data, exp ferr, exp perr
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 16'd16, 16, 1'b0, 1, 8'hA5, 0, 0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 16'd16, 16, 1'b0, 0, 8'h00, 1, 0};
    vecs[2] = '{8'h11, 1'b1, 1'b0, 16'd16, 16, 1'b0, 1, 8'h11, 0, 0};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 16'd16, 16, 1'b0, 1, 8'h00, 0, 0};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 16'd16, 16, 1'b0, 1, 8'hFF, 0, 0};
    vecs[5] = '{8'h96, 1'b1, 1'b0, 16'd1,  2,  1'b0, 1, 8'h96, 0, 0};
    vecs[6] = '{8'h5A, 1'b1, 1'b0, 16'd16, 16, 1'b1, 1, 8'h5A, 0, 0};
    vecs[7] = '{8'h07, 1'b1, 1'b1, 16'd16, 16, 1'b0, 1, 8'h07, 0, 0};
`ifdef UART_RX_PARITY_EN
    vecs[8] = '{8'h07, 1'b1, 1'b0, 16'd16, 16, 1'b0, 0, 8'h00, 0, 1};
`else
    vecs[8] = '{8'h07, 1'b1, 1'b0, 16'd16, 16, 1'b0, 1, 8'h07, 0, 0};
`endif

    for (int i = 0; i < NV; i++) begin
      clear_mon();
      baud_div = vecs[i].div;
      rx_ready = 1'b1;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].par, vecs[i].nb, vecs[i].swap);
      tick(20);
      check($sformatf("v%0d_valid_cycles", i), valid_cycles, vecs[i].exp_valid);
      if (vecs[i].exp_valid != 0) begin
        check($sformatf("v%0d_data", i), int'(last_data), int'(vecs[i].exp_data));
        check($sformatf("v%0d_latency_ok", i),
              int'((first_valid - start_cyc) <= ((19 + 2 * PAR) * vecs[i].nb) / 2 + 4), 1);
      end
      check($sformatf("v%0d_ferr", i), ferr_cnt, vecs[i].exp_ferr);
      check($sformatf("v%0d_ovr", i), ovr_cnt, 0);
`ifdef UART_RX_PARITY_EN
      check($sformatf("v%0d_perr", i), perr_cnt, vecs[i].exp_perr);
`endif
    end
    baud_div = 16'd16;

    // Short low glitch is rejected at the start-bit check
    clear_mon();
    drive_bit(1'b0, 4);
    rxd = 1'b1;
    tick(40);
    check("glitch_busy_seen", int'(busy_seen), 1);
    check("glitch_busy_end", int'(rx_busy), 0);
    check("glitch_valid", valid_cycles, 0);
    check("glitch_ferr", ferr_cnt, 0);

    // Back-to-back frames with a stalled consumer
    clear_mon();
    rx_ready = 1'b0;
    send_frame(8'h01, 1'b1, 1'b1, 16, 1'b0);
    send_frame(8'h02, 1'b1, 1'b1, 16, 1'b0);
    tick(20);
    check("ovr_pulses", ovr_cnt, 1);
    check("ovr_valid_held", int'(rx_valid), 1);
    check("ovr_data_held", int'(rx_data), 8'h01);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("ovr_hs_valid_clear", int'(rx_valid), 0);
    check("ovr_hs_count", acc_cnt, 1);
    check("ovr_hs_data", int'(last_data), 8'h01);
    rx_ready = 1'b1;

    // Reset in the middle of data bit 4 of 0xFF
    clear_mon();
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 16);
    tick(8);
    rst = 1'b0;
    tick(3);
    check("midrst_busy", int'(rx_busy), 0);
    check("midrst_valid", int'(rx_valid), 0);
    rst = 1'b1;
    tick(100);
    check("midrst_no_valid", valid_cycles, 0);
    check("midrst_no_ferr", ferr_cnt, 0);
    send_frame(8'h5A, 1'b1, 1'b0, 16, 1'b0);
    tick(20);
    check("midrst_next_count", valid_cycles, 1);
    check("midrst_next_data", int'(last_data), 8'h5A);

    // Line held low through reset release must not start a frame
    clear_mon();
    rxd = 1'b0;
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(40);
    check("lowrst_busy_seen", int'(busy_seen), 0);
    check("lowrst_ferr", ferr_cnt, 0);
    check("lowrst_valid", valid_cycles, 0);
    rxd = 1'b1;
    tick(20);
    send_frame(8'h33, 1'b1, 1'b0, 16, 1'b0);
    tick(20);
    check("lowrst_next_count", valid_cycles, 1);
    check("lowrst_next_data", int'(last_data), 8'h33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, default line rate in bit/s.
REQ-003 SHALL have parameter BAUD_CLOCK_NR, default CLOCK_FREQ/BAUD_RATE, default clocks per bit.
REQ-004 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous, active-low.
REQ-006 SHALL have port rxd, input, 1, asynchronous serial line, idle high.
REQ-007 SHALL have port baud_div, input, 16, runtime clocks per bit; 0 selects BAUD_CLOCK_NR.
REQ-008 SHALL have port rx_data, output, 8, received byte.
REQ-009 SHALL have port rx_valid, output, 1, rx_data holds an unconsumed byte.
REQ-010 SHALL have port rx_ready, input, 1, consumer accepts the byte.
REQ-011 SHALL have port rx_busy, output, 1, a frame is in progress (state not IDLE).
REQ-012 SHALL have port frame_err, output, 1, one-cycle pulse when the stop bit is sampled low.
REQ-013 SHALL have port overrun, output, 1, one-cycle pulse when a completed byte is dropped.

Function
REQ-014 SHALL pass rxd through a 2-flop synchronizer; both flops reset to 1.
REQ-015 SHALL latch the effective divisor N (baud_div, or BAUD_CLOCK_NR when baud_div is 0) on the start-edge detect; baud_div changes mid-frame SHALL be ignored.
REQ-016 SHALL implement the states IDLE, START, DATA, PARITY (macro only) and STOP, with a bit counter of 3 bits and a clock counter of 16 bits.
REQ-017 IDLE: on a synchronized falling edge (1 then 0), SHALL go to START and load the clock counter with N/2 - 1 (integer division).
REQ-018 START: at counter 0, SHALL go to DATA if the sampled rxd is 0 (counter reloaded to N-1, bit counter 0); otherwise SHALL treat it as a glitch and return to IDLE with no output.
REQ-019 DATA: every N clocks SHALL sample 8 bits, LSB first, into a shift register; after bit 7 SHALL go to STOP (or PARITY).
REQ-020 STOP: at mid-bit, SHALL on a sample of 1 deliver the byte; on 0 SHALL pulse frame_err, discard the byte and leave rx_valid unchanged; SHALL then go to IDLE at once, so that back-to-back frames are received.
REQ-021 SHALL drive rx_valid and rx_data from the clock edge following the stop-bit sample; rx_data SHALL stay stable while rx_valid is 1.
REQ-022 SHALL complete a handshake on a clock where rx_valid and rx_ready are both 1; rx_valid SHALL clear on the next edge unless a new byte is delivered on that same edge.
REQ-023 SHALL, on delivery while rx_valid is 1 with no handshake, pulse overrun and keep the old byte.
REQ-024 SHALL, on delivery coinciding with a handshake, load the new byte, keep rx_valid at 1 and not pulse overrun.
REQ-025 SHALL treat N < 2 as N = 2.

Reset
REQ-026 SHALL set on rst=0: state IDLE, counters 0, rx_data 0x00, rx_valid 0, rx_busy 0, frame_err 0, overrun 0, parity_err 0; a frame in progress SHALL be abandoned.
REQ-027 SHALL not accept a start edge until the synchronizer has seen rxd=1 after reset.

Configuration
REQ-028 SHALL, with UART_RX_PARITY_EN defined, add port parity_err (output, 1, one-cycle pulse) and port parity_odd (input, 1, 1=odd, 0=even), plus state PARITY between DATA and STOP that samples one parity bit.
REQ-029 SHALL, on a parity mismatch, pulse parity_err, discard the byte and still check the stop bit.
REQ-030 SHALL, without UART_RX_PARITY_EN, have neither the ports nor the state, and frame as 8N1.

Structure
REQ-031 SHALL place in uart_pkg the rx state enum (one-hot 5-bit), UART_DATA_BITS=8 and the synchronizer depth; a later uart_tx will share this package.
REQ-032 SHALL instantiate one sub-module, uart_sync, the 2-flop synchronizer with a reset value parameter.

Verification
REQ-033 SHALL cover: baud_div=16, frame 0xA5 8N1 on rxd, rx_ready=1 -> rx_valid for exactly 1 cycle with rx_data=0xA5, within 9.5*16+4 clocks of the start edge.
REQ-034 SHALL cover: baud_div=16, rxd low for 4 clocks then high -> returns to IDLE, no rx_valid, no frame_err.
REQ-035 SHALL cover: frame 0x3C with stop bit 0 -> frame_err pulse, rx_valid stays 0, next frame 0x11 received correctly.
REQ-036 SHALL cover: rx_ready=0, frames 0x01 then 0x02 back-to-back -> overrun pulse after the second frame, rx_data=0x01 held; then rx_ready=1 -> handshake, rx_valid=0.
REQ-037 SHALL cover: rst=0 at data bit 4 of 0xFF, then release and send 0x5A -> no output from the aborted frame, 0x5A received.
REQ-038 SHALL cover, with UART_RX_PARITY_EN, even parity: 0x07 with parity bit 1 accepted; 0x07 with parity bit 0 -> parity_err pulse, no rx_valid.
